// File: rtl/wb_req_pkg.sv
// Shared types and constants for the Wishbone burst request master.
package wb_req_pkg;

  // Bytes covered by one 32-bit Wishbone beat; also the address stride.
  localparam int BEAT_BYTES = 4;

  // Width of the beat-count field (beats minus one).
  localparam int LEN_W = 8;

  // Burst sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WDAT = 3'd1,
    BUS  = 3'd2,
    RDAT = 3'd3,
    END  = 3'd4
  } state_e;

endpackage

// File: rtl/wb_req_master.sv
// Wishbone classic burst master: turns one command into len+1 single-beat
// Wishbone cycles under a single cyc, with write data pulled from a stream
// and read data pushed to a stream, plus a per-beat timeout abort.
//
// Handshakes (req, wdat, rdat): a transfer happens on a rising edge where
// valid and ready are both 1. A source may not retract valid or change its
// payload until the transfer happens; ready carries no such obligation.
module wb_req_master
  import wb_req_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,   // only 32 is supported
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  // command
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [AW-1:0]    req_adr_i,
  input  logic             req_we_i,
  input  logic [3:0]       req_sel_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic             req_incr_i,
  // write-data stream
  input  logic             wdat_valid_i,
  output logic             wdat_ready_o,
  input  logic [DW-1:0]    wdat_i,
  // read-data stream
  output logic             rdat_valid_o,
  input  logic             rdat_ready_i,
  output logic [DW-1:0]    rdat_o,
  output logic             rdat_last_o,
  // burst status
  output logic             done_o,
  output logic             err_o,
  // Wishbone master
  output logic [AW-1:0]    wbm_adr_o,
  output logic [DW-1:0]    wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  input  logic [DW-1:0]    wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  // debug view of the sequencer
  output state_e           dbg_state_o
);

  // Wide enough to hold TIMEOUT itself.
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    adr_q,   adr_d;
  logic [DW-1:0]    dat_q,   dat_d;
  logic [DW-1:0]    rdat_q,  rdat_d;
  logic [3:0]       sel_q,   sel_d;
  logic             we_q,    we_d;
  logic             incr_q,  incr_d;
  logic             err_q,   err_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;
  logic [TW-1:0]    tmo_q,   tmo_d;

  // State and datapath registers; reset returns everything to zero / IDLE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      incr_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      incr_q  <= incr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and datapath updates for the burst sequencer.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    incr_d  = incr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    // Outside BUS the timeout counter sits at zero, so it is clear on entry.
    tmo_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          adr_d   = req_adr_i;
          sel_d   = req_sel_i;
          we_d    = req_we_i;
          incr_d  = req_incr_i;
          cnt_d   = req_len_i;
          err_d   = 1'b0;
          state_d = req_we_i ? WDAT : BUS;
        end
      end

      WDAT: begin
        if (wdat_valid_i) begin
          dat_d   = wdat_i;
          state_d = BUS;
        end
      end

      BUS: begin
        if (wbm_err_i) begin
          // Error has priority over a simultaneous ack.
          err_d   = 1'b1;
          state_d = END;
        end else if (wbm_ack_i) begin
          if (incr_q) adr_d = adr_q + AW'(BEAT_BYTES);
          if (we_q) begin
            if (cnt_q == '0) begin
              state_d = END;
            end else begin
              cnt_d   = cnt_q - LEN_W'(1);
              state_d = WDAT;
            end
          end else begin
            rdat_d  = wbm_dat_i;
            state_d = RDAT;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // This silent cycle is the TIMEOUT-th one with stb high.
          err_d   = 1'b1;
          state_d = END;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RDAT: begin
        if (rdat_ready_i) begin
          if (cnt_q == '0) begin
            state_d = END;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = BUS;
          end
        end
      end

      END: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state, so none are combinational
  // paths from inputs.
  assign req_ready_o  = (state_q == IDLE);
  assign wdat_ready_o = (state_q == WDAT);
  assign wbm_stb_o    = (state_q == BUS);
  assign wbm_cyc_o    = (state_q == WDAT) || (state_q == BUS) || (state_q == RDAT);
  assign rdat_valid_o = (state_q == RDAT);
  assign rdat_last_o  = (state_q == RDAT) && (cnt_q == '0);
  assign rdat_o       = rdat_q;
  assign done_o       = (state_q == END);
  assign err_o        = (state_q == END) && err_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_we_o     = we_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_wb_req_master.sv
// Directed bench for wb_req_master: a vector table of bursts against a
// behavioural Wishbone slave, plus hand-written timeout and reset sequences.
module tb_wb_req_master;
  import wb_req_pkg::*;

  // ---------------- clock / reset ----------------
  logic        wb_clk_i;
  logic        wb_rst_i;

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- DUT ----------------
  logic        req_valid_i, req_ready_o, req_we_i, req_incr_i;
  logic [31:0] req_adr_i;
  logic [3:0]  req_sel_i;
  logic [7:0]  req_len_i;
  logic        wdat_valid_i, wdat_ready_o;
  logic [31:0] wdat_i;
  logic        rdat_valid_o, rdat_ready_i, rdat_last_o;
  logic [31:0] rdat_o;
  logic        done_o, err_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
  state_e      dbg_state;

  wb_req_master #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_adr_i    (req_adr_i),
    .req_we_i     (req_we_i),
    .req_sel_i    (req_sel_i),
    .req_len_i    (req_len_i),
    .req_incr_i   (req_incr_i),
    .wdat_valid_i (wdat_valid_i),
    .wdat_ready_o (wdat_ready_o),
    .wdat_i       (wdat_i),
    .rdat_valid_o (rdat_valid_o),
    .rdat_ready_i (rdat_ready_i),
    .rdat_o       (rdat_o),
    .rdat_last_o  (rdat_last_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_ack_i    (wbm_ack_i),
    .wbm_err_i    (wbm_err_i),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- checking infrastructure ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int viol   = 0;

  logic [31:0] exp_q[$];       // expected read data, in order
  logic [31:0] exp_adr_q[$];   // expected address per slave response
  logic [31:0] exp_wdat_q[$];  // expected write data per slave response

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a, input int b);
    return a ^ {16'hC0DE, 8'h00, 8'(b)};
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [7:0]  len;
    logic        incr;
    int          ack_dly;   // stb cycles before the slave responds
    int          hold;      // cycles rdat_ready stays low per read beat
    int          err_beat;  // beat answered with err (-1 = none)
    logic        never;     // slave never answers
    logic [31:0] wbase;     // write data = wbase + beat
    logic        exp_err;
    int          exp_wcnt;  // write words consumed
    int          exp_rcnt;  // read words delivered
  } vec_t;

  // ---------------- behavioural slave ----------------
  int          ack_delay  = 0;
  int          err_beat   = -1;
  logic        never_ack  = 1'b0;
  logic        cur_we     = 1'b0;
  logic [3:0]  cur_sel    = 4'h0;
  int          slave_beat = 0;
  int          stb_hi_cnt = 0;

  initial begin
    int          stb_wait;
    logic        prev_resp, resp;
    logic [31:0] lat_adr, lat_dat;
    logic [3:0]  lat_sel;
    logic        lat_we;
    stb_wait  = 0;
    prev_resp = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge wb_clk_i);
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      resp      = 1'b0;
      if (wbm_stb_o === 1'b1) begin
        stb_hi_cnt++;
        if (prev_resp) viol++;  // stb must be low for a cycle between beats
        if (stb_wait == 0) begin
          lat_adr = wbm_adr_o; lat_dat = wbm_dat_o; lat_sel = wbm_sel_o; lat_we = wbm_we_o;
        end else if (lat_adr !== wbm_adr_o || lat_dat !== wbm_dat_o ||
                     lat_sel !== wbm_sel_o || lat_we !== wbm_we_o) begin
          viol++;
        end
        if (!never_ack && stb_wait == ack_delay) begin
          if (exp_adr_q.size() == 0) chk("bus_extra_beat", 32'd1, 32'd0);
          else chk("bus_adr", wbm_adr_o, exp_adr_q.pop_front());
          chk("bus_we", 32'(wbm_we_o), 32'(cur_we));
          chk("bus_sel", 32'(wbm_sel_o), 32'(cur_sel));
          if (cur_we) begin
            if (exp_wdat_q.size() == 0) chk("bus_extra_wdat", 32'd1, 32'd0);
            else chk("bus_wdat", wbm_dat_o, exp_wdat_q.pop_front());
          end
          wbm_ack_i = 1'b1;                        // ack alongside err: err must win
          if (slave_beat == err_beat) wbm_err_i = 1'b1;
          wbm_dat_i = rd_word(wbm_adr_o, slave_beat);
          slave_beat++;
          resp = 1'b1;
        end
        stb_wait++;
      end else begin
        stb_wait = 0;
      end
      prev_resp = resp;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic prep(input vec_t v);
    int          nresp;
    logic [31:0] a;
    ack_delay  = v.ack_dly;
    err_beat   = v.err_beat;
    never_ack  = v.never;
    cur_we     = v.we;
    cur_sel    = v.sel;
    slave_beat = 0;
    stb_hi_cnt = 0;
    viol       = 0;
    nresp = v.never ? 0 : (v.err_beat >= 0 ? v.err_beat + 1 : int'(v.len) + 1);
    for (int i = 0; i < nresp; i++) begin
      a = v.adr + (v.incr ? 32'(4 * i) : 32'd0);
      exp_adr_q.push_back(a);
      if (v.we) exp_wdat_q.push_back(v.wbase + 32'(i));
      else if (v.err_beat < 0 || i < v.err_beat) exp_q.push_back(rd_word(a, i));
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input vec_t v, input int tag);
    int w;
    w = 0;
    while (req_ready_o !== 1'b1 && w < 50) begin @(negedge wb_clk_i); w++; end
    chk($sformatf("v%0d_req_ready", tag), 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_adr_i   = v.adr;
    req_we_i    = v.we;
    req_sel_i   = v.sel;
    req_len_i   = v.len;
    req_incr_i  = v.incr;
    @(negedge wb_clk_i);
    req_valid_i = 1'b0;
    chk($sformatf("v%0d_cyc_rise", tag), 32'(wbm_cyc_o), 32'd1);
    chk($sformatf("v%0d_first_state", tag), 32'(dbg_state), 32'(v.we ? WDAT : BUS));
  endtask

  task automatic run_burst(input vec_t v, input int tag);
    int          wsent, rcnt, hold;
    logic [31:0] last_rd;
    logic        got_done, got_err, cyc_done;
    wsent = 0; rcnt = 0; hold = 0; last_rd = '0;
    got_done = 1'b0; got_err = 1'b0; cyc_done = 1'b1;
    prep(v);
    send_cmd(v, tag);
    for (int k = 0; k < 3000; k++) begin
      if (done_o === 1'b1) begin
        got_done = 1'b1; got_err = err_o; cyc_done = wbm_cyc_o;
        break;
      end
      wdat_valid_i = v.we && (wsent <= int'(v.len));
      wdat_i       = v.wbase + 32'(wsent);
      if (wdat_valid_i && wdat_ready_o) wsent++;
      rdat_ready_i = 1'b0;
      if (rdat_valid_o === 1'b1) begin
        if (wbm_stb_o) viol++;
        if (hold > 0 && rdat_o !== last_rd) viol++;
        last_rd = rdat_o;
        if (hold < v.hold) begin
          hold++;
        end else begin
          rdat_ready_i = 1'b1;
          if (exp_q.size() == 0) chk($sformatf("v%0d_rdat_extra", tag), 32'd1, 32'd0);
          else chk($sformatf("v%0d_rdat", tag), rdat_o, exp_q.pop_front());
          chk($sformatf("v%0d_rdat_last", tag), 32'(rdat_last_o), 32'(rcnt == int'(v.len)));
          rcnt++;
          hold = 0;
        end
      end
      @(negedge wb_clk_i);
    end
    wdat_valid_i = 1'b0;
    rdat_ready_i = 1'b0;
    chk($sformatf("v%0d_done", tag), 32'(got_done), 32'd1);
    chk($sformatf("v%0d_err", tag), 32'(got_err), 32'(v.exp_err));
    chk($sformatf("v%0d_cyc_at_done", tag), 32'(cyc_done), 32'd0);
    chk($sformatf("v%0d_wdat_cnt", tag), 32'(wsent), 32'(v.exp_wcnt));
    chk($sformatf("v%0d_rdat_cnt", tag), 32'(rcnt), 32'(v.exp_rcnt));
    chk($sformatf("v%0d_protocol_viol", tag), 32'(viol), 32'd0);
    chk($sformatf("v%0d_unserved", tag),
        32'(exp_adr_q.size() + exp_wdat_q.size() + exp_q.size()), 32'd0);
    exp_adr_q.delete(); exp_wdat_q.delete(); exp_q.delete();
    @(negedge wb_clk_i);
    chk($sformatf("v%0d_done_one_cycle", tag), 32'(done_o), 32'd0);
    chk($sformatf("v%0d_idle_after", tag), 32'(req_ready_o), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  vec_t vt, vr, vf;

  initial begin
    int rc, dn;
    //         we    adr            sel   len   incr dly hold errb never wbase           xerr wcnt rcnt
    vecs[0] = '{1'b1, 32'h0000_0010, 4'hF, 8'd0, 1'b1, 2, 0, -1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1, 0};
    vecs[1] = '{1'b0, 32'h0000_0100, 4'hF, 8'd3, 1'b1, 1, 5, -1, 1'b0, 32'h0000_0000, 1'b0, 0, 4};
    vecs[2] = '{1'b0, 32'h8000_0000, 4'hF, 8'd7, 1'b0, 0, 0, -1, 1'b0, 32'h0000_0000, 1'b0, 0, 8};
    vecs[3] = '{1'b1, 32'h0000_0200, 4'hF, 8'd3, 1'b1, 0, 0,  1, 1'b0, 32'h1111_0000, 1'b1, 2, 0};
    vecs[4] = '{1'b1, 32'hFFFF_FFF8, 4'h3, 8'd2, 1'b1, 1, 1, -1, 1'b0, 32'hA000_0000, 1'b0, 3, 0};
    vecs[5] = '{1'b0, 32'h0000_0040, 4'hC, 8'd1, 1'b1, 1, 2,  0, 1'b0, 32'h0000_0000, 1'b1, 0, 0};
    vt      = '{1'b0, 32'h0000_0300, 4'hF, 8'd0, 1'b1, 0, 0, -1, 1'b1, 32'h0000_0000, 1'b1, 0, 0};
    vr      = '{1'b0, 32'h0000_0500, 4'hF, 8'd3, 1'b1, 0, 0, -1, 1'b0, 32'h0000_0000, 1'b0, 0, 4};
    vf      = '{1'b0, 32'h0000_0600, 4'h5, 8'd1, 1'b1, 1, 1, -1, 1'b0, 32'h0000_0000, 1'b0, 0, 2};

    wb_rst_i     = 1'b1;
    req_valid_i  = 1'b0;
    req_adr_i    = '0;
    req_we_i     = 1'b0;
    req_sel_i    = '0;
    req_len_i    = '0;
    req_incr_i   = 1'b0;
    wdat_valid_i = 1'b0;
    wdat_i       = '0;
    rdat_ready_i = 1'b0;

    // Reset values.
    repeat (2) @(negedge wb_clk_i);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
    chk("rst_streams", {30'd0, wdat_ready_o, rdat_valid_o}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Table of bursts.
    for (int i = 0; i < 6; i++) run_burst(vecs[i], i);

    // Timeout: slave silent, stb must stay up exactly TIMEOUT (16) cycles.
    run_burst(vt, 80);
    chk("tmo_stb_cycles", 32'(stb_hi_cnt), 32'd16);

    // Reset in the middle of a read, while beat 1 is on the bus.
    prep(vr);
    send_cmd(vr, 90);
    rc = 0;
    for (int k = 0; k < 200; k++) begin
      if (rc == 1 && wbm_stb_o === 1'b1) break;
      rdat_ready_i = rdat_valid_o;
      if (rdat_valid_o === 1'b1) rc++;
      @(negedge wb_clk_i);
    end
    chk("rstmid_reached_beat1", {31'd0, wbm_stb_o}, 32'd1);
    rdat_ready_i = 1'b0;
    wb_rst_i     = 1'b1;
    @(negedge wb_clk_i);
    chk("rstmid_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("rstmid_done_err", {30'd0, done_o, err_o}, 32'd0);
    chk("rstmid_req_ready", 32'(req_ready_o), 32'd1);
    dn = 0;
    repeat (2) begin
      @(negedge wb_clk_i);
      if (done_o !== 1'b0 || err_o !== 1'b0) dn++;
    end
    wb_rst_i = 1'b0;
    chk("rstmid_no_done_pulse", 32'(dn), 32'd0);
    exp_adr_q.delete(); exp_wdat_q.delete(); exp_q.delete();
    @(negedge wb_clk_i);

    // A command after the reset completes normally.
    run_burst(vf, 91);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
